// File: rtl/qhttp_session_engine.sv
// qhttp_session_engine: multi-session Instaweb <-> QCI teleportation bridge.
// Each session slot moves FREE -> WAIT_EPR -> WAIT_BELL -> FREE. Responses are
// queued in a small TX FIFO. Coherence deadlines, the cycle counter and the
// background expiry scan exist only when QHTTP_DEADLINE_EN is defined.
module qhttp_session_engine #(
    parameter int NUM_SESSIONS   = 4,
    parameter int PRIO_THRESHOLD = 100,
    parameter int TXQ_DEPTH      = 4
) (
    input  logic                              clk_1g,
    input  logic                              rst_n,
    input  logic [511:0]                      rx_data,
    input  logic                              rx_valid,
    output logic                              rx_ready,
    output logic [511:0]                      tx_data,
    output logic                              tx_valid,
    input  logic                              tx_ready,
    input  logic [127:0]                      qubit_id,
    input  logic                              qubit_ready,
    input  logic [63:0]                       coherence_deadline,
    output logic                              qubit_ack,
    output logic [1:0]                        pauli_gate,
    output logic                              apply_gate,
    output logic [127:0]                      apply_qubit_id,
    input  logic                              emergency_override,
    output logic [$clog2(NUM_SESSIONS+1)-1:0] active_sessions,
    output logic [15:0]                       drop_count
);

    localparam int SW = (NUM_SESSIONS > 1) ? $clog2(NUM_SESSIONS) : 1;
    localparam int QW = $clog2(TXQ_DEPTH);
    localparam int CW = $clog2(TXQ_DEPTH + 1);
    localparam logic [31:0] PRIO_LIM = PRIO_THRESHOLD;

    localparam logic [7:0] T_ENT     = 8'h01;
    localparam logic [7:0] T_EPR     = 8'h02;
    localparam logic [7:0] T_BELL    = 8'h03;
    localparam logic [7:0] T_CORR    = 8'h04;
    localparam logic [7:0] T_TIMEOUT = 8'h05;
    localparam logic [7:0] T_REJECT  = 8'h06;

    typedef enum logic [1:0] {
        S_FREE      = 2'd0,
        S_WAIT_EPR  = 2'd1,
        S_WAIT_BELL = 2'd2
    } slot_state_t;

    // Incoming frame fields
    logic [7:0]   f_type;
    logic [7:0]   f_prio;
    logic [127:0] f_id;
    logic [1:0]   f_bell;
    logic         prio_pass;
    logic         unused_rx;

    assign f_type    = rx_data[7:0];
    assign f_prio    = rx_data[23:16];
    assign f_id      = rx_data[159:32];
    assign f_bell    = rx_data[161:160];
    assign prio_pass = ({24'd0, f_prio} <= PRIO_LIM) || emergency_override;
    assign unused_rx = ^{rx_data[511:162], rx_data[31:24], rx_data[15:8]};

    // Session slots
    slot_state_t  slot_state     [NUM_SESSIONS];
    slot_state_t  slot_state_nxt [NUM_SESSIONS];
    logic [127:0] slot_id        [NUM_SESSIONS];

    // Slot update request from the arbiter (at most one slot per cycle)
    logic          slot_we;
    logic [SW-1:0] slot_idx;
    slot_state_t   slot_new;
    logic          id_we;

    // Lookup results
    logic          held_hit;
    logic          free_hit;
    logic [SW-1:0] free_idx;
    logic          epr_hit;
    logic [SW-1:0] epr_idx;
    logic          bell_hit;
    logic [SW-1:0] bell_idx;
    logic          bell_late;

    // TX queue
    logic [135:0]  q_mem [TXQ_DEPTH];
    logic [QW-1:0] wr_ptr;
    logic [QW-1:0] rd_ptr;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          push;
    logic          pop;
    logic [7:0]    push_type;
    logic [127:0]  push_id;

    logic drop;
    logic apply_nxt;

`ifdef QHTTP_DEADLINE_EN
    logic [63:0]   now;
    logic [63:0]   slot_dl [NUM_SESSIONS];
    logic          dl_we;
    logic [SW-1:0] scan_ptr;
    logic          scan_en;
    logic          scan_expired;

    assign bell_late    = now > slot_dl[bell_idx];
    assign scan_expired = (slot_state[scan_ptr] == S_WAIT_BELL) && (now > slot_dl[scan_ptr]);
`else
    logic unused_dl;

    assign bell_late = 1'b0;
    assign unused_dl = ^coherence_deadline;
`endif

    assign q_full   = (q_count == CW'(TXQ_DEPTH));
    assign rx_ready = !q_full;
    assign tx_valid = (q_count != '0);
    assign pop      = tx_valid && tx_ready;
    assign tx_data  = tx_valid ? {376'd0, q_mem[rd_ptr]} : '0;

    // Associative lookups over all slots; descending loop leaves the lowest index
    always_comb begin
        held_hit = 1'b0;
        free_hit = 1'b0;
        free_idx = '0;
        epr_hit  = 1'b0;
        epr_idx  = '0;
        bell_hit = 1'b0;
        bell_idx = '0;
        for (int i = NUM_SESSIONS - 1; i >= 0; i--) begin
            if (slot_state[i] != S_FREE && slot_id[i] == f_id) begin
                held_hit = 1'b1;
            end
            if (slot_state[i] == S_FREE) begin
                free_hit = 1'b1;
                free_idx = SW'(i);
            end
            if (slot_state[i] == S_WAIT_EPR && slot_id[i] == qubit_id) begin
                epr_hit = 1'b1;
                epr_idx = SW'(i);
            end
            if (slot_state[i] == S_WAIT_BELL && slot_id[i] == f_id) begin
                bell_hit = 1'b1;
                bell_idx = SW'(i);
            end
        end
    end

    // Occupied-slot count
    always_comb begin
        active_sessions = '0;
        for (int i = 0; i < NUM_SESSIONS; i++) begin
            if (slot_state[i] != S_FREE) begin
                active_sessions = active_sessions + 1'b1;
            end
        end
    end

    // Arbiter and event decode: rx frame, then qubit_ready, then expiry scan
    always_comb begin
        push      = 1'b0;
        push_type = 8'h00;
        push_id   = '0;
        drop      = 1'b0;
        qubit_ack = 1'b0;
        apply_nxt = 1'b0;
        slot_we   = 1'b0;
        slot_idx  = '0;
        slot_new  = S_FREE;
        id_we     = 1'b0;
`ifdef QHTTP_DEADLINE_EN
        dl_we     = 1'b0;
        scan_en   = 1'b0;
`endif
        if (rx_valid && rx_ready) begin
            if (!prio_pass) begin
                drop = 1'b1;
            end else begin
                case (f_type)
                    T_ENT: begin
                        if (held_hit || !free_hit) begin
                            push      = 1'b1;
                            push_type = T_REJECT;
                            push_id   = f_id;
                        end else begin
                            slot_we  = 1'b1;
                            slot_idx = free_idx;
                            slot_new = S_WAIT_EPR;
                            id_we    = 1'b1;
                        end
                    end
                    T_BELL: begin
                        if (bell_hit) begin
                            slot_we  = 1'b1;
                            slot_idx = bell_idx;
                            slot_new = S_FREE;
                            push     = 1'b1;
                            push_id  = f_id;
                            if (bell_late) begin
                                push_type = T_TIMEOUT;
                            end else begin
                                push_type = T_CORR;
                                apply_nxt = 1'b1;
                            end
                        end else begin
                            drop = 1'b1;
                        end
                    end
                    default: drop = 1'b1;
                endcase
            end
        end else if (qubit_ready && !q_full) begin
            qubit_ack = 1'b1;
            if (epr_hit) begin
                slot_we   = 1'b1;
                slot_idx  = epr_idx;
                slot_new  = S_WAIT_BELL;
                push      = 1'b1;
                push_type = T_EPR;
                push_id   = qubit_id;
`ifdef QHTTP_DEADLINE_EN
                dl_we     = 1'b1;
`endif
            end
`ifdef QHTTP_DEADLINE_EN
        end else if (!q_full) begin
            scan_en = 1'b1;
            if (scan_expired) begin
                slot_we   = 1'b1;
                slot_idx  = scan_ptr;
                slot_new  = S_FREE;
                push      = 1'b1;
                push_type = T_TIMEOUT;
                push_id   = slot_id[scan_ptr];
            end
`endif
        end
    end

    // Slot next-state: apply the single granted update
    always_comb begin
        for (int i = 0; i < NUM_SESSIONS; i++) begin
            slot_state_nxt[i] = slot_state[i];
        end
        if (slot_we) begin
            slot_state_nxt[slot_idx] = slot_new;
        end
    end

    // Slot state register; reset aborts every session at once
    always_ff @(posedge clk_1g or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SESSIONS; i++) begin
                slot_state[i] <= S_FREE;
            end
        end else begin
            for (int i = 0; i < NUM_SESSIONS; i++) begin
                slot_state[i] <= slot_state_nxt[i];
            end
        end
    end

    // Slot qubit id capture on allocation (payload only, meaningful when not FREE)
    always_ff @(posedge clk_1g) begin
        if (id_we) begin
            slot_id[slot_idx] <= f_id;
        end
    end

`ifdef QHTTP_DEADLINE_EN
    // Deadline capture when the EPR pair becomes ready
    always_ff @(posedge clk_1g) begin
        if (dl_we) begin
            slot_dl[slot_idx] <= coherence_deadline;
        end
    end

    // Free-running cycle counter and round-robin expiry pointer
    always_ff @(posedge clk_1g or negedge rst_n) begin
        if (!rst_n) begin
            now      <= 64'd0;
            scan_ptr <= '0;
        end else begin
            now <= now + 64'd1;
            if (scan_en) begin
                scan_ptr <= (scan_ptr == SW'(NUM_SESSIONS - 1)) ? '0 : scan_ptr + 1'b1;
            end
        end
    end
`endif

    // TX queue storage write
    always_ff @(posedge clk_1g) begin
        if (push) begin
            q_mem[wr_ptr] <= {push_id, push_type};
        end
    end

    // TX queue pointers and occupancy; pushes are only granted when not full
    always_ff @(posedge clk_1g or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // Correction strobe, gate/target hold registers and saturating drop counter
    always_ff @(posedge clk_1g or negedge rst_n) begin
        if (!rst_n) begin
            apply_gate     <= 1'b0;
            pauli_gate     <= 2'b00;
            apply_qubit_id <= '0;
            drop_count     <= 16'd0;
        end else begin
            apply_gate <= apply_nxt;
            if (apply_nxt) begin
                pauli_gate     <= f_bell;
                apply_qubit_id <= f_id;
            end
            if (drop && drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_qhttp_session_engine.sv
// Directed bench for qhttp_session_engine with a TX-frame scoreboard.
// Deadline-dependent steps follow QHTTP_DEADLINE_EN.
`timescale 1ns/1ps
module tb_qhttp_session_engine;

    localparam int NS = 4;
    localparam logic [7:0] T_ENT  = 8'h01;
    localparam logic [7:0] T_EPR  = 8'h02;
    localparam logic [7:0] T_BELL = 8'h03;
    localparam logic [7:0] T_CORR = 8'h04;
    localparam logic [7:0] T_TMO  = 8'h05;
    localparam logic [7:0] T_REJ  = 8'h06;

    logic         clk_1g = 1'b0;
    logic         rst_n;
    logic [511:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [511:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [127:0] qubit_id;
    logic         qubit_ready;
    logic [63:0]  coherence_deadline;
    logic         qubit_ack;
    logic [1:0]   pauli_gate;
    logic         apply_gate;
    logic [127:0] apply_qubit_id;
    logic         emergency_override;
    logic [2:0]   active_sessions;
    logic [15:0]  drop_count;

    int           checks = 0;
    int           failures = 0;
    logic [135:0] exp_q [$];
    logic [63:0]  tb_now;
    int           apply_cnt = 0;
    int           exp_drop = 0;

    qhttp_session_engine #(
        .NUM_SESSIONS(NS),
        .PRIO_THRESHOLD(100),
        .TXQ_DEPTH(4)
    ) dut (
        .clk_1g(clk_1g),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .qubit_id(qubit_id),
        .qubit_ready(qubit_ready),
        .coherence_deadline(coherence_deadline),
        .qubit_ack(qubit_ack),
        .pauli_gate(pauli_gate),
        .apply_gate(apply_gate),
        .apply_qubit_id(apply_qubit_id),
        .emergency_override(emergency_override),
        .active_sessions(active_sessions),
        .drop_count(drop_count)
    );

    always #5 clk_1g = ~clk_1g;

    // Reference cycle counter, mirrors the spec'd free-running 'now'
    always @(posedge clk_1g or negedge rst_n) begin
        if (!rst_n) tb_now <= 64'd0;
        else        tb_now <= tb_now + 64'd1;
    end

    function automatic logic [135:0] fr(input logic [7:0] t, input logic [127:0] id);
        return {id, t};
    endfunction

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1g);
        #1;
    endtask

    // Scoreboard monitor: every handshaken frame must match the oldest expectation
    initial begin
        logic         stall_prev;
        logic [511:0] data_prev;
        logic [135:0] e;
        stall_prev = 1'b0;
        data_prev  = '0;
        forever begin
            @(negedge clk_1g);
            if (apply_gate === 1'b1) apply_cnt++;
            if (rst_n === 1'b1) begin
                if (stall_prev) begin
                    checks++;
                    assert (tx_data === data_prev) else begin
                        failures++;
                        $error("FAIL tx_stable observed=%0h expected=%0h", tx_data[135:0], data_prev[135:0]);
                    end
                end
                if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        failures++;
                        $error("FAIL tx_unexpected observed=%0h expected=none", tx_data[135:0]);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checks++;
                        assert (tx_data === {376'd0, e}) else begin
                            failures++;
                            $error("FAIL tx_frame observed=%0h expected=%0h", tx_data[135:0], e);
                        end
                    end
                end
                stall_prev = (tx_valid === 1'b1) && (tx_ready === 1'b0);
            end else begin
                stall_prev = 1'b0;
            end
            data_prev = tx_data;
        end
    end

    task automatic send_rx(input logic [7:0] t, input logic [7:0] p, input logic [127:0] id,
                           input logic [1:0] b);
        int n;
        n = 0;
        rx_data            = '0;
        rx_data[7:0]       = t;
        rx_data[23:16]     = p;
        rx_data[159:32]    = id;
        rx_data[161:160]   = b;
        rx_valid           = 1'b1;
        while (rx_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("rx_ready_wait", 136'(n < 64), 136'(1));
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_qr(input logic [127:0] id, input logic [63:0] dl);
        qubit_id           = id;
        coherence_deadline = dl;
        qubit_ready        = 1'b1;
        exp_q.push_back(fr(T_EPR, id));
        #1;
        chk("qubit_ack", 136'(qubit_ack), 136'(1));
        tick();
        qubit_ready = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("drain", 136'(exp_q.size()), 136'(0));
    endtask

    task automatic wait_now(input logic [63:0] target);
        int n;
        n = 0;
        while (tb_now < target && n < 1000) begin
            tick();
            n++;
        end
        chk("now_reached", 136'(tb_now), 136'(target));
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_tx_valid"}, 136'(tx_valid), 136'(0));
        chk({pfx, "_tx_data"}, 136'(tx_data == '0), 136'(1));
        chk({pfx, "_apply_gate"}, 136'(apply_gate), 136'(0));
        chk({pfx, "_pauli_gate"}, 136'(pauli_gate), 136'(0));
        chk({pfx, "_apply_id"}, 136'(apply_qubit_id), 136'(0));
        chk({pfx, "_qubit_ack"}, 136'(qubit_ack), 136'(0));
        chk({pfx, "_active"}, 136'(active_sessions), 136'(0));
        chk({pfx, "_drop"}, 136'(drop_count), 136'(0));
        chk({pfx, "_rx_ready"}, 136'(rx_ready), 136'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n              = 1'b0;
        rx_data            = '0;
        rx_valid           = 1'b0;
        tx_ready           = 1'b1;
        qubit_id           = '0;
        qubit_ready        = 1'b0;
        coherence_deadline = '0;
        emergency_override = 1'b0;
        #2;
        chk_reset("rst0");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic session: allocate, EPR ready, in-deadline correction
        send_rx(T_ENT, 8'd50, 128'hA5, 2'b00);
        chk("t1_active1", 136'(active_sessions), 136'(1));
        chk("t1_no_frame", 136'(tx_valid), 136'(0));
        send_qr(128'hA5, 64'd1000);
        chk("t1_epr_tx_valid", 136'(tx_valid), 136'(1));
        repeat (3) tick();
        exp_q.push_back(fr(T_CORR, 128'hA5));
        send_rx(T_BELL, 8'd50, 128'hA5, 2'b11);
        chk("t1_apply", 136'(apply_gate), 136'(1));
        chk("t1_pauli", 136'(pauli_gate), 136'(3));
        chk("t1_apply_id", 136'(apply_qubit_id), 136'hA5);
        chk("t1_corr_tx_valid", 136'(tx_valid), 136'(1));
        chk("t1_active0", 136'(active_sessions), 136'(0));
        tick();
        chk("t1_apply_pulse", 136'(apply_gate), 136'(0));
        wait_drain();

        // Priority check and emergency override
        send_rx(T_ENT, 8'd200, 128'hB1, 2'b00);
        exp_drop++;
        chk("t2_drop", 136'(drop_count), 136'(exp_drop));
        chk("t2_no_alloc", 136'(active_sessions), 136'(0));
        emergency_override = 1'b1;
        send_rx(T_ENT, 8'd200, 128'hB1, 2'b00);
        emergency_override = 1'b0;
        chk("t2_override_alloc", 136'(active_sessions), 136'(1));
        chk("t2_drop_hold", 136'(drop_count), 136'(exp_drop));

        // Duplicate id and slot exhaustion
        exp_q.push_back(fr(T_REJ, 128'hB1));
        send_rx(T_ENT, 8'd10, 128'hB1, 2'b00);
        chk("t3_dup_active", 136'(active_sessions), 136'(1));
        send_rx(T_ENT, 8'd10, 128'hC1, 2'b00);
        send_rx(T_ENT, 8'd10, 128'hC2, 2'b00);
        send_rx(T_ENT, 8'd100, 128'hC3, 2'b00);
        chk("t3_full", 136'(active_sessions), 136'(4));
        exp_q.push_back(fr(T_REJ, 128'hC4));
        send_rx(T_ENT, 8'd10, 128'hC4, 2'b00);
        chk("t3_full_hold", 136'(active_sessions), 136'(4));
        wait_drain();
        send_qr(128'hC3, 64'hFFFF_FFFF_FFFF_FFFF);
        exp_q.push_back(fr(T_CORR, 128'hC3));
        send_rx(T_BELL, 8'd10, 128'hC3, 2'b01);
        chk("t3_pauli", 136'(pauli_gate), 136'(1));
        chk("t3_active3", 136'(active_sessions), 136'(3));
        wait_drain();

        // Asynchronous reset with three sessions and a queued frame
        tx_ready = 1'b0;
        send_rx(T_ENT, 8'd10, 128'hC1, 2'b00);
        chk("rst_pre_queued", 136'(tx_valid), 136'(1));
        rst_n = 1'b0;
        #1;
        chk_reset("rst1");
        tx_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        exp_drop = 0;
        repeat (6) tick();
        chk("rst_post_tx_valid", 136'(tx_valid), 136'(0));
        chk("rst_post_active", 136'(active_sessions), 136'(0));

        // Coherence deadline
        send_rx(T_ENT, 8'd10, 128'hD1, 2'b00);
        send_qr(128'hD1, 64'd100);
        wait_drain();
`ifdef QHTTP_DEADLINE_EN
        wait_now(64'd100);
        chk("t4_no_early_timeout", 136'(active_sessions), 136'(1));
        exp_q.push_back(fr(T_TMO, 128'hD1));
        wait_now(64'd100 + NS + 1);
        chk("t4_timeout_freed", 136'(active_sessions), 136'(0));
        tick();
        chk("t4_timeout_frame", 136'(exp_q.size()), 136'(0));
        cnt = apply_cnt;
        send_rx(T_BELL, 8'd10, 128'hD1, 2'b10);
        exp_drop++;
        tick();
        chk("t4_late_bell_drop", 136'(drop_count), 136'(exp_drop));
        chk("t4_late_bell_no_apply", 136'(apply_cnt), 136'(cnt));
`else
        wait_now(64'd110);
        exp_q.push_back(fr(T_CORR, 128'hD1));
        send_rx(T_BELL, 8'd10, 128'hD1, 2'b10);
        chk("t4_late_bell_apply", 136'(apply_gate), 136'(1));
        chk("t4_late_bell_pauli", 136'(pauli_gate), 136'(2));
        wait_drain();
        chk("t4_active0", 136'(active_sessions), 136'(0));
`endif

        // Unknown type and unmatched BELL_MEASURE
        send_rx(8'h7F, 8'd10, 128'h77, 2'b00);
        exp_drop++;
        chk("unknown_drop", 136'(drop_count), 136'(exp_drop));
        send_rx(T_BELL, 8'd10, 128'h99, 2'b01);
        exp_drop++;
        chk("unmatched_bell_drop", 136'(drop_count), 136'(exp_drop));
        chk("drop_active0", 136'(active_sessions), 136'(0));

        // Backpressure: fill slots, then queue four REJECTs with tx_ready low
        for (int k = 0; k < 4; k++) begin
            send_rx(T_ENT, 8'd10, 128'h100 + 128'(k), 2'b00);
        end
        chk("t5_slots_full", 136'(active_sessions), 136'(4));
        tx_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(fr(T_REJ, 128'h200 + 128'(k)));
            send_rx(T_ENT, 8'd10, 128'h200 + 128'(k), 2'b00);
        end
        chk("t5_rx_ready_low", 136'(rx_ready), 136'(0));
        chk("t5_head", tx_data[135:0], fr(T_REJ, 128'h200));
        qubit_id           = 128'h100;
        coherence_deadline = 64'hFFFF_FFFF_FFFF_FFFF;
        qubit_ready        = 1'b1;
        #1;
        chk("t5_ack_withheld", 136'(qubit_ack), 136'(0));
        tick();
        chk("t5_ack_withheld2", 136'(qubit_ack), 136'(0));
        exp_q.push_back(fr(T_EPR, 128'h100));
        tx_ready = 1'b1;
        #1;
        chk("t5_rx_ready_pop_cycle", 136'(rx_ready), 136'(0));
        chk("t5_ack_pop_cycle", 136'(qubit_ack), 136'(0));
        tick();
        chk("t5_ack_after_pop", 136'(qubit_ack), 136'(1));
        tick();
        qubit_ready = 1'b0;
        wait_drain();
        chk("t5_active", 136'(active_sessions), 136'(4));

        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qhttp_session_engine.md
# qhttp_session_engine

Multi-session successor to the single-handshake qhttp bridge between the Instaweb classical link and the QCI quantum control interface. Tracks up to NUM_SESSIONS concurrent teleportation sessions, each progressing independently through entanglement, EPR-ready notification and Pauli correction. Enforces real coherence deadlines against a hardware cycle counter. Buffers outgoing Instaweb frames in a backpressured TX queue.

## Interface
- NUM_SESSIONS, 4: concurrent session slots (1..16).
- PRIO_THRESHOLD, 100: highest priority value that passes the constitutional check.
- TXQ_DEPTH, 4: TX frame queue depth (power of two, ≥2).

- clk_1g  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  512  Instaweb frame: [7:0] type, [23:16] priority, [159:32] qubit id, [161:160] Bell result.
- rx_valid  in  1  frame valid; consumed when rx_valid & rx_ready.
- rx_ready  out  1  1 when TX queue not full.
- tx_data  out  512  [7:0] type, [135:8] qubit id, rest 0.
- tx_valid  out  1  queue head valid.
- tx_ready  in  1  downstream accept; pop on tx_valid & tx_ready.
- qubit_id  in  128  QCI qubit id.
- qubit_ready  in  1  EPR pair ready for qubit_id.
- coherence_deadline  in  64  absolute cycle count after which the qubit is decohered.
- qubit_ack  out  1  one-cycle pulse: qubit_ready event consumed.
- pauli_gate  out  2  correction gate (= Bell result).
- apply_gate  out  1  one-cycle correction strobe.
- apply_qubit_id  out  128  target of apply_gate.
- emergency_override  in  1  bypasses priority check.
- active_sessions  out  clog2(NUM_SESSIONS+1)  occupied slots.
- drop_count  out  16  saturating count of dropped rx frames.

## Operation
- Slot state: FREE, WAIT_EPR, WAIT_BELL; each slot holds a qubit id and a 64-bit deadline.
- Pass = (priority ≤ PRIO_THRESHOLD) | emergency_override. Failing frames are dropped and drop_count is incremented.
- 0x01 ENTANGLEMENT_REQ: id already held by a slot, or no FREE slot -> push 0x06 REJECT. Otherwise the lowest-index FREE slot -> WAIT_EPR.
- qubit_ready: matching WAIT_EPR slot -> store deadline, push 0x02 EPR_READY, slot -> WAIT_BELL. No matching slot -> ack and discard.
- 0x03 BELL_MEASURE, matching WAIT_BELL slot:
  - now ≤ deadline -> pauli_gate/apply_qubit_id loaded, apply_gate=1, push 0x04 CORRECTION_APPLIED, slot -> FREE.
  - now > deadline -> push 0x05 TIMEOUT, slot -> FREE, no apply.
- Unmatched BELL_MEASURE or unknown type: dropped, drop_count++.
- Expiry scan: one slot per cycle, round-robin pointer. A WAIT_BELL slot with now > deadline -> 0x05 TIMEOUT, FREE.
- `now`: 64-bit free-running counter, unsigned compare; wrap is not handled.
- Per-cycle arbitration, at most one queue push per cycle:
  - rx frame first.
  - qubit_ready second: only when no rx frame is accepted and the queue has space; qubit_ack asserted that cycle.
  - expiry scan third: skipped without advancing its pointer.

## Timing
- Reset values: tx_valid 0, tx_data 0, apply_gate 0, pauli_gate 0, apply_qubit_id 0, qubit_ack 0, active_sessions 0, drop_count 0, all slots FREE, queue empty, now 0. rx_ready is 1 after reset.
- Reset asserted mid-operation aborts all sessions immediately; no TIMEOUT frames are emitted.
- Rx accepted in cycle N:
  - apply_gate high in cycle N+1, exactly one cycle.
  - Response frame has tx_valid in N+1 if the queue was empty.
- qubit_ready sampled in N -> qubit_ack in N, EPR_READY tx_valid in N+1.
- tx_data/tx_valid stay stable while tx_valid & !tx_ready.
- Simultaneous push and pop on a full queue is legal. rx_ready uses registered occupancy only, so it stays 0 that cycle.
- Slot freed in cycle N is allocatable from cycle N+1.

## Configuration
- QHTTP_DEADLINE_EN defined: counter, late-BELL check and expiry scan present.
- QHTTP_DEADLINE_EN undefined:
  - No counter, no expiry scan, deadline not stored.
  - 0x05 is never emitted.
  - Matching BELL_MEASURE always applies the correction.

## Test plan
- ENTANGLEMENT_REQ id=0xA5, priority 50 -> slot 0 WAIT_EPR, active_sessions=1. qubit_ready id=0xA5, deadline 1000 -> EPR_READY 0x02 id 0xA5. BELL_MEASURE bell=2'b11 at now=500 -> apply_gate one cycle, pauli_gate=3, 0x04 frame, active_sessions=0.
- Priority 200, override 0 -> no state change, drop_count=1. Same frame with override 1 -> session allocated.
- Five ENTANGLEMENT_REQs with distinct ids, NUM_SESSIONS=4 -> fifth answered 0x06. Duplicate id -> 0x06.
- Deadline 100, no BELL_MEASURE -> 0x05 TIMEOUT by now=100+NUM_SESSIONS+1. A later BELL_MEASURE for that id -> dropped, no apply_gate.
- tx_ready held 0 with TXQ_DEPTH=4 -> rx_ready drops after 4 pushes. qubit_ack is withheld while the queue is full. Release -> frames drain in push order.
- rst_n pulsed with 3 active sessions -> all outputs at reset values within the same cycle, no frames emitted.
